// File: rtl/ras_stack.sv
// Return-address stack. A circular buffer keeps the newest DEPTH call targets;
// when the buffer is full, a push overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [AW-1:0]                addr_i,
  output logic [AW-1:0]                top_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] entry_q [DEPTH];
  logic [PW-1:0] tos_q, tos_d, tos_inc, tos_dec, waddr;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          we;

  // DEPTH need not be a power of two, so the pointer wraps by compare.
  assign tos_inc = (tos_q == LAST) ? '0 : tos_q + PW'(1);
  assign tos_dec = (tos_q == '0) ? LAST : tos_q - PW'(1);

  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    we          = 1'b0;
    waddr       = tos_q;
    if (flush_i) begin
      tos_d   = '0;
      count_d = '0;
    end else if (push_i && pop_i && (count_q != '0)) begin
      // Return immediately followed by a call: replace the top in place.
      we = 1'b1;
    end else if (push_i) begin
      tos_d = tos_inc;
      we    = 1'b1;
      waddr = tos_inc;
      if (count_q == FULL) overflow_d = 1'b1;
      else                 count_d    = count_q + CW'(1);
    end else if (pop_i) begin
      if (count_q != '0) begin
        tos_d   = tos_dec;
        count_d = count_q - CW'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (we) begin
      entry_q[waddr] <= addr_i;
    end
  end

  assign top_o       = entry_q[tos_q];
  assign valid_o     = (count_q != '0);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack (DEPTH=2): directed scenarios plus a
// randomized run checked against a queue-based stack model.
module tb_ras_stack;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 64;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst, flush, push, pop;
  logic [AW-1:0] addr;
  logic [AW-1:0] top;
  logic          valid, ovf, unf;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string         name;
    logic          fl, pu, po;
    logic [AW-1:0] a;
    logic          tc;
    logic [AW-1:0] top;
    logic          v;
    logic [CW-1:0] c;
    logic          ov, un;
  } step_t;

  step_t stim[$];
  step_t sb[$];
  logic [AW-1:0] mq[$];

  ras_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
    .addr_i(addr), .top_o(top), .valid_o(valid), .count_o(count),
    .overflow_o(ovf), .underflow_o(unf)
  );

  always #5 clk = ~clk;

  function automatic step_t S(string n, bit fl, bit pu, bit po, logic [AW-1:0] a,
                              bit tc, logic [AW-1:0] t, bit v, int c, bit ov, bit un);
    step_t s;
    s.name = n; s.fl = fl; s.pu = pu; s.po = po; s.a = a;
    s.tc = tc; s.top = t; s.v = v; s.c = CW'(c); s.ov = ov; s.un = un;
    return s;
  endfunction

  // Runs the queued stimulus; each expectation enters the scoreboard as its
  // stimulus is driven and is retired when the outputs are sampled.
  task automatic run_stim();
    step_t e;
    while (stim.size() > 0) begin
      e = stim.pop_front();
      flush = e.fl; push = e.pu; pop = e.po; addr = e.a;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({valid, count, ovf, unf} !== {e.v, e.c, e.ov, e.un} || (e.tc && top !== e.top)) begin
        n_err++;
        $display("FAIL %s: got top=%h valid=%b count=%0d ovf=%b unf=%b, want top=%h(care=%b) valid=%b count=%0d ovf=%b unf=%b",
                 e.name, top, valid, count, ovf, unf, e.top, e.tc, e.v, e.c, e.ov, e.un);
      end
    end
    flush = 0; push = 0; pop = 0; addr = '0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; push = 0; pop = 0; addr = '0;
    @(negedge clk);
    n_cmp++;
    if ({top, valid, count, ovf, unf} !== {{AW{1'b0}}, 1'b0, {CW{1'b0}}, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got top=%h valid=%b count=%0d ovf=%b unf=%b, want all 0", top, valid, count, ovf, unf);
    end
    rst = 0;
  endtask

  task automatic test_push_pop();
    stim.push_back(S("pp_push1", 0,1,0, 64'h1000, 1, 64'h1000, 1, 1, 0, 0));
    stim.push_back(S("pp_push2", 0,1,0, 64'h2000, 1, 64'h2000, 1, 2, 0, 0));
    stim.push_back(S("pp_pop1",  0,0,1, 64'h0,    1, 64'h1000, 1, 1, 0, 0));
    stim.push_back(S("pp_pop2",  0,0,1, 64'h0,    0, 64'h0,    0, 0, 0, 0));
    run_stim();
  endtask

  task automatic test_overflow();
    stim.push_back(S("ov_pushA", 0,1,0, 64'hA, 1, 64'hA, 1, 1, 0, 0));
    stim.push_back(S("ov_pushB", 0,1,0, 64'hB, 1, 64'hB, 1, 2, 0, 0));
    stim.push_back(S("ov_pushC", 0,1,0, 64'hC, 1, 64'hC, 1, 2, 1, 0));
    stim.push_back(S("ov_idle",  0,0,0, 64'h0, 1, 64'hC, 1, 2, 0, 0));
    stim.push_back(S("ov_pop1",  0,0,1, 64'h0, 1, 64'hB, 1, 1, 0, 0));
    stim.push_back(S("ov_pop2",  0,0,1, 64'h0, 0, 64'h0, 0, 0, 0, 0));
    run_stim();
  endtask

  task automatic test_underflow();
    stim.push_back(S("un_pop",      0,0,1, 64'h0,  0, 64'h0,  0, 0, 0, 1));
    stim.push_back(S("un_idle",     0,0,0, 64'h0,  0, 64'h0,  0, 0, 0, 0));
    stim.push_back(S("un_pushpop",  0,1,1, 64'h40, 1, 64'h40, 1, 1, 0, 0));
    stim.push_back(S("un_pop_last", 0,0,1, 64'h0,  0, 64'h0,  0, 0, 0, 0));
    run_stim();
  endtask

  task automatic test_push_pop_same();
    stim.push_back(S("sm_push10",   0,1,0, 64'h10, 1, 64'h10, 1, 1, 0, 0));
    stim.push_back(S("sm_push20",   0,1,0, 64'h20, 1, 64'h20, 1, 2, 0, 0));
    stim.push_back(S("sm_pushpop",  0,1,1, 64'h30, 1, 64'h30, 1, 2, 0, 0));
    stim.push_back(S("sm_pop",      0,0,1, 64'h0,  1, 64'h10, 1, 1, 0, 0));
    stim.push_back(S("sm_pop_last", 0,0,1, 64'h0,  0, 64'h0,  0, 0, 0, 0));
    run_stim();
  endtask

  task automatic test_flush();
    stim.push_back(S("fl_push1",   0,1,0, 64'h1,  1, 64'h1, 1, 1, 0, 0));
    stim.push_back(S("fl_push2",   0,1,0, 64'h2,  1, 64'h2, 1, 2, 0, 0));
    stim.push_back(S("fl_flush",   1,1,0, 64'h99, 0, 64'h0, 0, 0, 0, 0));
    stim.push_back(S("fl_push5",   0,1,0, 64'h5,  1, 64'h5, 1, 1, 0, 0));
    stim.push_back(S("fl_flushpp", 1,0,1, 64'h0,  0, 64'h0, 0, 0, 0, 0));
    stim.push_back(S("fl_popempty",0,0,1, 64'h0,  0, 64'h0, 0, 0, 0, 1));
    stim.push_back(S("fl_flushclr",1,0,0, 64'h0,  0, 64'h0, 0, 0, 0, 0));
    run_stim();
  endtask

  task automatic test_async_reset();
    stim.push_back(S("ar_push7", 0,1,0, 64'h7, 1, 64'h7, 1, 1, 0, 0));
    stim.push_back(S("ar_push8", 0,1,0, 64'h8, 1, 64'h8, 1, 2, 0, 0));
    run_stim();
    push = 1; addr = 64'h9;
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({top, valid, count, ovf, unf} !== {{AW{1'b0}}, 1'b0, {CW{1'b0}}, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got top=%h valid=%b count=%0d ovf=%b unf=%b, want all 0", top, valid, count, ovf, unf);
    end
    @(posedge clk);
    @(negedge clk);
    push = 0; addr = '0; rst = 0;
    stim.push_back(S("ar_idle",   0,0,0, 64'h0,  1, 64'h0,  0, 0, 0, 0));
    stim.push_back(S("ar_push55", 0,1,0, 64'h55, 1, 64'h55, 1, 1, 0, 0));
    stim.push_back(S("ar_pop",    0,0,1, 64'h0,  0, 64'h0,  0, 0, 0, 0));
    run_stim();
  endtask

  task automatic test_back_to_back();
    bit fl, pu, po, ov, un;
    logic [AW-1:0] a;
    mq.delete();
    for (int i = 0; i < 300; i++) begin
      fl = ($urandom_range(0, 19) == 0);
      pu = $urandom_range(0, 1);
      po = $urandom_range(0, 1);
      a  = {$urandom, $urandom};
      ov = 0; un = 0;
      if (fl) mq.delete();
      else if (pu && po && mq.size() > 0) mq[mq.size()-1] = a;
      else if (pu) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          ov = 1;
        end
        mq.push_back(a);
      end else if (po) begin
        if (mq.size() > 0) void'(mq.pop_back());
        else un = 1;
      end
      stim.push_back(S($sformatf("rnd%0d", i), fl, pu, po, a, mq.size() > 0,
                       (mq.size() > 0) ? mq[mq.size()-1] : '0, mq.size() > 0,
                       mq.size(), ov, un));
    end
    run_stim();
  endtask

  initial begin
    rst = 1; flush = 0; push = 0; pop = 0; addr = '0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_push_pop_same();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
